// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory port master.
//   DATA_W  - memory word width
//   BE_W    - byte-enable width (one bit per byte of DATA_W)
//   state_e - top-level FSM: INIT clears the memory, RUN serves requests
package mem_port_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_port_master_if.sv
// Request/response handshake bundle between a client and mem_port_master.
//   req_valid/req_ready  - request handshake (client -> port)
//   req_write            - 1 = write, 0 = read
//   req_addr             - word address
//   req_wdata/req_be     - write data and byte mask
//   rsp_valid/rsp_ready  - read response handshake (port -> client)
//   rsp_data             - read data
//   init_done            - memory clear finished, requests are served from now on
// Modports: slave = memory port side, master = client side.
interface mem_port_master_if
  import mem_port_pkg::*;
#(
  parameter int unsigned LOG_MEM_SIZE = 4
) ();

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [LOG_MEM_SIZE-1:0] req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic [BE_W-1:0]         req_be;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic                    init_done;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_data, init_done
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, init_done
  );

endinterface

// File: rtl/mem_rsp_fifo.sv
// Two-entry response FIFO holding read data in request order.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_push     - write i_wdata (ignored when full unless popping in the same cycle)
//   i_wdata    - data to enqueue
//   i_pop      - drop the head entry (ignored when empty)
//   o_rdata    - head entry, stable until popped
//   o_full     - both entries occupied
//   o_empty    - no entry occupied
module mem_rsp_fifo
  import mem_port_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  // Pop is evaluated first so a push into a full FIFO is accepted when the head leaves.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/mem_port_master.sv
// Drives a byte-enabled single-cycle memory: clears it after reset, then serves
// read/write requests with in-order read responses through a 2-entry FIFO.
//   clk, rst_n        - clock, asynchronous active-low reset
//   io_bus            - request/response handshake (slave side) plus init_done
//   o_mem_write_en    - memory write strobe (registered)
//   o_mem_byte_en     - memory byte enables (registered)
//   o_mem_write_addr  - memory write address (registered)
//   o_mem_write_data  - memory write data (registered)
//   o_mem_read_addr   - memory read address (registered)
//   i_mem_read_data   - combinational memory data at o_mem_read_addr
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int unsigned MEM_SIZE     = 16,
  parameter int unsigned LOG_MEM_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_port_master_if.slave        io_bus,
  output logic                    o_mem_write_en,
  output logic [BE_W-1:0]         o_mem_byte_en,
  output logic [LOG_MEM_SIZE-1:0] o_mem_write_addr,
  output logic [DATA_W-1:0]       o_mem_write_data,
  output logic [LOG_MEM_SIZE-1:0] o_mem_read_addr,
  input  logic [DATA_W-1:0]       i_mem_read_data
);

  // One extra bit so the counter can reach MEM_SIZE, meaning "last clear already driven".
  localparam logic [LOG_MEM_SIZE:0] CLR_END = (LOG_MEM_SIZE+1)'(MEM_SIZE);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [LOG_MEM_SIZE:0]   r_clr_cnt;
  logic [LOG_MEM_SIZE:0]   w_clr_cnt_next;
  logic                    r_rd_pending;
  logic                    w_rd_pending_next;

  logic                    r_mem_write_en;
  logic [BE_W-1:0]         r_mem_byte_en;
  logic [LOG_MEM_SIZE-1:0] r_mem_write_addr;
  logic [DATA_W-1:0]       r_mem_write_data;
  logic [LOG_MEM_SIZE-1:0] r_mem_read_addr;
  logic                    w_mem_write_en_next;
  logic [BE_W-1:0]         w_mem_byte_en_next;
  logic [LOG_MEM_SIZE-1:0] w_mem_write_addr_next;
  logic [DATA_W-1:0]       w_mem_write_data_next;
  logic [LOG_MEM_SIZE-1:0] w_mem_read_addr_next;

  logic [DATA_W-1:0]       w_fifo_rdata;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [1:0]              w_fifo_level;
  logic [1:0]              w_outstanding;
  logic                    w_rsp_valid;
  logic                    w_pop;
  logic                    w_req_ready;
  logic                    w_req_fire;

  // Response path ----------------------------------------------------------

  assign w_rsp_valid  = !w_fifo_empty;
  assign w_pop        = w_rsp_valid && io_bus.rsp_ready;
  assign w_fifo_level = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);

  // A read is in flight for exactly one cycle (address driven, data captured at
  // the end of it), so outstanding never exceeds the FIFO depth.
  assign w_outstanding = {1'b0, r_rd_pending} + w_fifo_level;
  assign w_req_ready   = (r_state == RUN) && ((w_outstanding < 2'd2) || w_pop);
  assign w_req_fire    = io_bus.req_valid && w_req_ready;

  mem_rsp_fifo u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_pending),
    .i_wdata (i_mem_read_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // FSM and memory-port next state -------------------------------------------

  always_comb begin
    w_state_next          = r_state;
    w_clr_cnt_next        = r_clr_cnt;
    w_rd_pending_next     = 1'b0;
    w_mem_write_en_next   = 1'b0;
    w_mem_byte_en_next    = '0;
    w_mem_write_addr_next = r_mem_write_addr;
    w_mem_write_data_next = r_mem_write_data;
    w_mem_read_addr_next  = r_mem_read_addr;

    unique case (r_state)
      INIT: begin
        if (r_clr_cnt < CLR_END) begin
          w_mem_write_en_next   = 1'b1;
          w_mem_byte_en_next    = '1;
          w_mem_write_addr_next = r_clr_cnt[LOG_MEM_SIZE-1:0];
          w_mem_write_data_next = '0;
          w_clr_cnt_next        = r_clr_cnt + 1'b1;
        end else begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_req_fire) begin
          if (io_bus.req_write) begin
            // An all-zero mask is accepted but never reaches the memory.
            if (io_bus.req_be != '0) begin
              w_mem_write_en_next   = 1'b1;
              w_mem_byte_en_next    = io_bus.req_be;
              w_mem_write_addr_next = io_bus.req_addr;
              w_mem_write_data_next = io_bus.req_wdata;
            end
          end else begin
            w_mem_read_addr_next = io_bus.req_addr;
            w_rd_pending_next    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= INIT;
      r_clr_cnt        <= '0;
      r_rd_pending     <= 1'b0;
      r_mem_write_en   <= 1'b0;
      r_mem_byte_en    <= '0;
      r_mem_write_addr <= '0;
      r_mem_write_data <= '0;
      r_mem_read_addr  <= '0;
    end else begin
      r_state          <= w_state_next;
      r_clr_cnt        <= w_clr_cnt_next;
      r_rd_pending     <= w_rd_pending_next;
      r_mem_write_en   <= w_mem_write_en_next;
      r_mem_byte_en    <= w_mem_byte_en_next;
      r_mem_write_addr <= w_mem_write_addr_next;
      r_mem_write_data <= w_mem_write_data_next;
      r_mem_read_addr  <= w_mem_read_addr_next;
    end
  end

  // Outputs ------------------------------------------------------------------

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_data  = w_fifo_rdata;
  assign io_bus.init_done = (r_state == RUN);

  assign o_mem_write_en   = r_mem_write_en;
  assign o_mem_byte_en    = r_mem_byte_en;
  assign o_mem_write_addr = r_mem_write_addr;
  assign o_mem_write_data = r_mem_write_data;
  assign o_mem_read_addr  = r_mem_read_addr;

endmodule

// File: tb/tb_mem_port_master.sv
// Self-checking bench for mem_port_master with a behavioural memory and a
// request-level reference model (word array + queue of expected responses).
module tb_mem_port_master;

  localparam int unsigned MEM_SIZE = 16;
  localparam int unsigned LOG_MEM_SIZE = 4;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_port_master_if #(.LOG_MEM_SIZE(LOG_MEM_SIZE)) bus ();

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [3:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] phys [MEM_SIZE];

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;

  logic [31:0] model_mem [MEM_SIZE];
  exp_t        expq [$];
  logic [31:0] last_rsp = '0;
  logic        prev_run = 1'b0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_be;
  logic [3:0]  exp_waddr;
  logic [31:0] exp_wdata;

  mem_port_master #(
    .MEM_SIZE     (MEM_SIZE),
    .LOG_MEM_SIZE (LOG_MEM_SIZE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .io_bus           (bus),
    .o_mem_write_en   (mem_we),
    .o_mem_byte_en    (mem_be),
    .o_mem_write_addr (mem_waddr),
    .o_mem_write_data (mem_wdata),
    .o_mem_read_addr  (mem_raddr),
    .i_mem_read_data  (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached memory: byte-enabled write at the clock edge, combinational read.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) phys[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end
  assign mem_rdata = phys[mem_raddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Monitor: sampled on the falling edge, i.e. describes the upcoming rising edge.
  always @(negedge clk) begin
    logic pop;
    logic allowed;
    if (!rst_n) begin
      prev_run = 1'b0;
      exp_we   = 1'b0;
    end else begin
      pop = bus.rsp_valid && bus.rsp_ready;
      if (prev_run) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
          check("mem_be", 32'(mem_be), 32'(exp_be));
          check("mem_waddr", 32'(mem_waddr), 32'(exp_waddr));
          check("mem_wdata", mem_wdata, exp_wdata);
        end
        check("req_ready", 32'(bus.req_ready), 32'((expq.size() < 2) || pop));
      end
      if (bus.rsp_valid) begin
        allowed = (expq.size() > 0) && (cyc >= expq[0].cyc + 2);
        check("rsp_allowed", 32'(allowed), 32'd1);
        if (expq.size() > 0) check("rsp_data", bus.rsp_data, expq[0].data);
        if (pop && expq.size() > 0) begin
          last_rsp = bus.rsp_data;
          void'(expq.pop_front());
        end
      end
      exp_we = 1'b0;
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_write) begin
          model_mem[bus.req_addr] = merge_be(model_mem[bus.req_addr], bus.req_wdata, bus.req_be);
          exp_we    = (bus.req_be != 4'h0);
          exp_be    = bus.req_be;
          exp_waddr = bus.req_addr;
          exp_wdata = bus.req_wdata;
        end else begin
          expq.push_back('{data: model_mem[bus.req_addr], cyc: cyc});
        end
      end
      prev_run = bus.init_done;
    end
  end

  task automatic assert_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    expq.delete();
    for (int i = 0; i < MEM_SIZE; i++) model_mem[i] = '0;
  endtask

  // Called just after reset release; ends one step after a rising edge.
  task automatic init_check();
    for (int k = 0; k < MEM_SIZE; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("clr_we", 32'(mem_we), 32'd1);
      check("clr_addr", 32'(mem_waddr), 32'(k));
      check("clr_be", 32'(mem_be), 32'hF);
      check("clr_data", mem_wdata, 32'h0);
      check("clr_ready", 32'(bus.req_ready), 32'd0);
      check("clr_done", 32'(bus.init_done), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check("init_done", 32'(bus.init_done), 32'd1);
    check("init_we_off", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    logic acc;
    acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    logic [31:0] v7;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < MEM_SIZE; i++) phys[i] = $urandom;
    assert_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    rst_n = 1'b1;
    init_check();

    // Every word reads back as zero, one read per cycle.
    c0 = cyc;
    for (int a = 0; a < MEM_SIZE; a++) issue(1'b0, 4'(a), 32'h0, 4'h0);
    check("b2b_cycles", cyc - c0, 32'd16);
    drain();

    issue(1'b1, 4'd3, 32'hAABBCCDD, 4'hF);
    issue(1'b1, 4'd3, 32'h11223344, 4'b0101);
    issue(1'b0, 4'd3, 32'h0, 4'h0);
    drain();
    check("be_merge", last_rsp, 32'hAA22CC44);

    issue(1'b1, 4'd5, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 4'd5, 32'h0, 4'h0);
    drain();
    check("be_zero", last_rsp, 32'h0);

    // Full outstanding window stalls the third read until a response drains.
    v7 = $urandom;
    issue(1'b1, 4'd1, 32'h0101_0101, 4'hF);
    issue(1'b1, 4'd2, 32'h0202_0202, 4'hF);
    issue(1'b1, 4'd7, v7, 4'hF);
    drain();
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'd1, 32'h0, 4'h0);
    issue(1'b0, 4'd2, 32'h0, 4'h0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 4'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    issue(1'b0, 4'd7, 32'h0, 4'h0);
    drain();
    check("order_last", last_rsp, v7);

    issue(1'b1, 4'd9, 32'h12345678, 4'hF);
    issue(1'b0, 4'd9, 32'h0, 4'h0);
    drain();
    check("raw_fwd", last_rsp, 32'h12345678);

    // Random traffic with random response back-pressure.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = ($urandom_range(0, 2) != 0);
      bus.req_write = $urandom_range(0, 1) == 1;
      bus.req_addr  = 4'($urandom_range(0, MEM_SIZE - 1));
      bus.req_wdata = $urandom;
      bus.req_be    = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with two queued responses: responses vanish at once.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'd1, 32'h0, 4'h0);
    issue(1'b0, 4'd2, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("queued_valid", 32'(bus.rsp_valid), 32'd1);
    assert_reset();
    #1;
    check("rst_drop_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_drop_data", bus.rsp_data, 32'd0);
    check("rst_drop_ready", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset again while the clear of address 8 is on the port.
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("clr8_addr", 32'(mem_waddr), 32'(k));
    end
    #1;
    assert_reset();
    #1;
    check("clr8_we", 32'(mem_we), 32'd0);
    check("clr8_waddr", 32'(mem_waddr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_check();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int a = 0; a < MEM_SIZE; a++) issue(1'b0, 4'(a), 32'h0, 4'h0);
    drain();
    check("post_rst_zero", last_rsp, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_master.md
MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 16, number of 32-bit words in the attached memory.
REQ-002 SHALL have parameter LOG_MEM_SIZE, default 4, memory address width.
REQ-003 SHALL use one clock; reset asynchronous, active-low; ports clk, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request offered.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  LOG_MEM_SIZE  word address.
REQ-010 req_wdata  input  32  write data.
REQ-011 req_be  input  4  byte mask; bit i enables bits [8i+7:8i].
REQ-012 rsp_valid  output  1  read response available.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_data  output  32  read data.
REQ-015 init_done  output  1  memory clear complete; requests are served only after this.
REQ-016 mem_write_en, mem_byte_en[4], mem_write_addr[LOG_MEM_SIZE], mem_write_data[32], mem_read_addr[LOG_MEM_SIZE]  outputs  drive the byte-enabled memory port, all registered.
REQ-017 mem_read_data  input  32  combinational read data of the memory at mem_read_addr.

Function
REQ-018 SHALL implement FSM states INIT and RUN; reset enters INIT; INIT -> RUN after the last clear write; no exit from RUN except reset.
REQ-019 In INIT: one word cleared per cycle, addresses 0..MEM_SIZE-1 ascending, mem_write_en=1, mem_byte_en=4'hF, mem_write_data=0; req_ready=0; init_done=0.
REQ-020 init_done SHALL rise in the cycle after the clear of address MEM_SIZE-1 is driven, and stay 1.
REQ-021 req_ready = RUN && (outstanding < 2 || response pop this cycle); outstanding = reads issued but not yet captured + response FIFO occupancy (0..2); no dependence on req_write.
REQ-022 Write accepted in cycle N: mem_write_en=1, mem_byte_en=req_be, address/data from the request, driven in cycle N+1 only.
REQ-023 Write with req_be==0: accepted, mem_write_en held 0, no memory change.
REQ-024 Read accepted in cycle N: mem_read_addr=req_addr in N+1; mem_read_data captured at end of N+1; rsp_valid in N+2 at earliest.
REQ-025 Responses SHALL be returned in request order through a 2-entry FIFO; rsp_data stable while rsp_valid && !rsp_ready.
REQ-026 Write then read of the same address in consecutive accepted cycles SHALL return the written bytes (write commits end of N+1, read samples end of N+2).
REQ-027 Simultaneous push and pop on a full FIFO SHALL be legal with occupancy unchanged; no overflow or underflow under any input sequence.
REQ-028 Back-to-back reads with rsp_ready=1 continuously SHALL sustain one request per cycle.
REQ-029 mem_write_en=0 in every RUN cycle without an accepted nonzero-mask write.

Reset
REQ-030 On rst_n low: state=INIT, clear counter=0, outstanding=0, FIFO empty, rsp_valid=0, rsp_data=0, init_done=0, req_ready=0, mem_write_en=0, mem_byte_en=0, addresses and mem_write_data=0.
REQ-031 Reset during INIT or RUN SHALL discard in-flight reads and queued responses and restart the clear from address 0.

Structure
REQ-032 Shared package mem_port_pkg SHALL hold DATA_W=32, BE_W=4, and the FSM state enum (INIT, RUN).
REQ-033 The response FIFO SHALL be a sub-module mem_rsp_fifo (2 entries, 32 bits, push/pop/full/empty).

Verification
REQ-034 Reset release, MEM_SIZE=16 -> 16 consecutive clear writes addr 0..15, be=4'hF, data 0; init_done high in the 17th cycle; reading every address returns 0.
REQ-035 Write addr 3 data 32'hAABBCCDD be 4'hF, then write addr 3 data 32'h11223344 be 4'b0101, then read 3 -> rsp_data 32'hAA22CC44.
REQ-036 Write addr 5 be 4'h0 data 32'hFFFFFFFF -> mem_write_en stays 0; read 5 returns 0.
REQ-037 rsp_ready=0, issue 3 reads to addrs 1,2,7 -> first two accepted, req_ready low for the third until rsp_ready=1; responses returned in order 1,2,7.
REQ-038 Write addr 9 32'h12345678 in cycle N, read 9 in N+1 -> rsp_data 32'h12345678.
REQ-039 Pull rst_n low at clear address 8 with 2 queued responses -> rsp_valid 0 immediately; clear restarts at 0; no stale response appears.
